// File: rtl/sos_scheduler.sv
// Arbitrates the periodic auto-beacon and manual burst requests onto one SOS
// pattern engine, enforcing an inter-message gap and an engine-hang timeout.
module sos_scheduler #(
  parameter int PERIOD_CNT  = 150_000_000,
  parameter int GAP_CNT     = 25_000_000,
  parameter int TIMEOUT_CNT = 100_000_000,
  parameter int CNT_W       = 28
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       Auto_En,
  input  logic       Manual_Req,
  input  logic [3:0] Repeat_Num,
  input  logic       SOS_Done_Sig,
  input  logic       Clear_Err,
  output logic       SOS_En_Sig,
  output logic       Busy,
  output logic       Timeout_Err,
  output logic [3:0] Remain_Cnt
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_RUN, S_GAP} state_t;

  localparam logic [CNT_W-1:0] C_PERIOD_LAST = CNT_W'(PERIOD_CNT - 1);
  localparam logic [CNT_W-1:0] C_GAP_LAST    = CNT_W'(GAP_CNT - 1);
  localparam logic [CNT_W-1:0] C_TO_LAST     = CNT_W'(TIMEOUT_CNT - 1);
  localparam logic [CNT_W-1:0] C_ONE         = CNT_W'(1);

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_auto_cnt;
  logic [CNT_W-1:0] r_to_cnt;
  logic [CNT_W-1:0] r_gap_cnt;
  logic             r_auto_pend;
  logic             r_man_pend;
  logic [3:0]       r_man_num;
  logic [3:0]       r_remain;
  logic             r_en;
  logic             r_err;

  logic w_load_man;
  logic w_load_auto;
  logic w_done_hit;
  logic w_to_hit;
  logic w_gap_end;
  logic w_auto_wrap;

  assign w_auto_wrap = (r_auto_cnt == C_PERIOD_LAST);

  always_comb begin
    w_next_state = r_state;
    w_load_man   = 1'b0;
    w_load_auto  = 1'b0;
    w_done_hit   = 1'b0;
    w_to_hit     = 1'b0;
    w_gap_end    = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Manual wins; a concurrent auto request stays pending for later.
        if (r_man_pend) begin
          w_load_man   = 1'b1;
          w_next_state = S_START;
        end else if (r_auto_pend) begin
          w_load_auto  = 1'b1;
          w_next_state = S_START;
        end
      end
      S_START: w_next_state = S_RUN;
      S_RUN: begin
        if (SOS_Done_Sig) begin
          w_done_hit   = 1'b1;
          w_next_state = S_GAP;
        end else if (r_to_cnt == C_TO_LAST) begin
          w_to_hit     = 1'b1;
          w_next_state = S_GAP;
        end
      end
      S_GAP: begin
        if (r_gap_cnt == C_GAP_LAST) begin
          w_gap_end = 1'b1;
          if (r_remain != 4'd0) begin
            w_next_state = S_START;
          end else begin
            w_next_state = S_IDLE;
          end
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_auto_cnt  <= '0;
      r_auto_pend <= 1'b0;
    end else if (!Auto_En) begin
      r_auto_cnt  <= '0;
      r_auto_pend <= 1'b0;
    end else begin
      r_auto_cnt <= w_auto_wrap ? '0 : r_auto_cnt + C_ONE;
      if (w_auto_wrap) begin
        r_auto_pend <= 1'b1;
      end else if (w_load_auto) begin
        r_auto_pend <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_man_pend <= 1'b0;
      r_man_num  <= 4'd0;
    end else if (w_load_man) begin
      r_man_pend <= 1'b0;
    end else if (Manual_Req && !r_man_pend) begin
      r_man_pend <= 1'b1;
      r_man_num  <= (Repeat_Num == 4'd0) ? 4'd1 : Repeat_Num;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_en      <= 1'b0;
      r_remain  <= 4'd0;
      r_to_cnt  <= '0;
      r_gap_cnt <= '0;
      r_err     <= 1'b0;
    end else begin
      r_en <= (w_next_state == S_START);
      if (w_load_man) begin
        r_remain <= r_man_num;
      end else if (w_load_auto) begin
        r_remain <= 4'd1;
      end else if (w_done_hit) begin
        r_remain <= r_remain - 4'd1;
      end else if (w_to_hit) begin
        r_remain <= 4'd0;
      end
      r_to_cnt  <= (r_state == S_RUN) ? r_to_cnt + C_ONE : '0;
      r_gap_cnt <= (r_state == S_GAP && !w_gap_end) ? r_gap_cnt + C_ONE : '0;
      if (w_to_hit) begin
        r_err <= 1'b1;
      end else if (Clear_Err) begin
        r_err <= 1'b0;
      end
    end
  end

  assign SOS_En_Sig  = r_en;
  assign Busy        = (r_state != S_IDLE);
  assign Timeout_Err = r_err;
  assign Remain_Cnt  = r_remain;

endmodule

// File: tb/tb_sos_scheduler.sv
// Directed bench for sos_scheduler: expected start pulses (cycle, remaining
// count) are queued when a request is driven and matched as pulses appear.
module tb_sos_scheduler;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b1;
  logic       Auto_En = 1'b0;
  logic       Manual_Req = 1'b0;
  logic [3:0] Repeat_Num = 4'd0;
  logic       SOS_Done_Sig = 1'b0;
  logic       Clear_Err = 1'b0;
  logic       SOS_En_Sig;
  logic       Busy;
  logic       Timeout_Err;
  logic [3:0] Remain_Cnt;

  sos_scheduler #(
    .PERIOD_CNT (100),
    .GAP_CNT    (10),
    .TIMEOUT_CNT(50),
    .CNT_W      (28)
  ) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .Auto_En     (Auto_En),
    .Manual_Req  (Manual_Req),
    .Repeat_Num  (Repeat_Num),
    .SOS_Done_Sig(SOS_Done_Sig),
    .Clear_Err   (Clear_Err),
    .SOS_En_Sig  (SOS_En_Sig),
    .Busy        (Busy),
    .Timeout_Err (Timeout_Err),
    .Remain_Cnt  (Remain_Cnt)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int cyc;
    int rem;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   done_at = -1;
  int   eng_dly = 20;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  // One clock; engine model returns done eng_dly cycles after each start (0 = hung).
  task automatic step();
    @(posedge CLK);
    #1;
    cyc++;
    SOS_Done_Sig = (cyc == done_at);
    if (SOS_En_Sig === 1'b1) begin
      n_assert++;
      assert (sb.size() != 0) else begin
        n_fail++;
        $error("FAIL pulse_unexpected: SOS_En_Sig at cycle %0d, none queued", cyc);
      end
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("pulse_cycle", cyc, e.cyc);
        chk("pulse_remain", {28'd0, Remain_Cnt}, e.rem);
      end
      done_at = (eng_dly > 0) ? cyc + eng_dly : -1;
    end
  endtask

  task automatic run_to(input int c);
    while (cyc < c) step();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_en"}, {31'd0, SOS_En_Sig}, 0);
    chk({tag, "_busy"}, {31'd0, Busy}, 0);
    chk({tag, "_err"}, {31'd0, Timeout_Err}, 0);
    chk({tag, "_remain"}, {28'd0, Remain_Cnt}, 0);
  endtask

  task automatic apply_reset();
    RST_N = 1'b0;
    #1;
    check_all_zero("rst");
    step();
    step();
    RST_N = 1'b1;
    done_at = -1;
    SOS_Done_Sig = 1'b0;
  endtask

  task automatic manual(input int num);
    Manual_Req = 1'b1;
    Repeat_Num = 4'(num);
    step();
    Manual_Req = 1'b0;
  endtask

  int k;
  int s;
  int a;
  int r;

  initial begin
    #2;
    apply_reset();

    // Manual single with Repeat_Num=0 (treated as 1)
    k = cyc;
    sb.push_back('{k + 2, 1});
    manual(0);
    run_to(k + 2);
    chk("single_busy_start", {31'd0, Busy}, 1);
    chk("single_remain", {28'd0, Remain_Cnt}, 1);
    run_to(k + 22);
    chk("single_remain_at_done", {28'd0, Remain_Cnt}, 1);
    run_to(k + 23);
    chk("single_remain_after", {28'd0, Remain_Cnt}, 0);
    run_to(k + 32);
    chk("single_busy_gap_end", {31'd0, Busy}, 1);
    run_to(k + 33);
    chk("single_idle", {31'd0, Busy}, 0);
    run_to(k + 40);

    // Manual burst of 3: pulses 31 cycles apart
    k = cyc;
    sb.push_back('{k + 2, 3});
    sb.push_back('{k + 33, 2});
    sb.push_back('{k + 64, 1});
    manual(3);
    run_to(k + 85);
    chk("burst_remain_end", {28'd0, Remain_Cnt}, 0);
    run_to(k + 95);
    chk("burst_idle", {31'd0, Busy}, 0);
    chk("burst_sb_empty", sb.size(), 0);

    // Hung engine: timeout aborts the rest of a 3-message burst
    eng_dly = 0;
    k = cyc;
    s = k + 2;
    sb.push_back('{s, 3});
    manual(3);
    run_to(s + 50);
    chk("to_err_before", {31'd0, Timeout_Err}, 0);
    run_to(s + 51);
    chk("to_err_set", {31'd0, Timeout_Err}, 1);
    chk("to_remain_abort", {28'd0, Remain_Cnt}, 0);
    run_to(s + 60);
    chk("to_busy_gap", {31'd0, Busy}, 1);
    run_to(s + 61);
    chk("to_idle", {31'd0, Busy}, 0);
    run_to(s + 120);
    chk("to_sb_empty", sb.size(), 0);
    chk("to_err_sticky", {31'd0, Timeout_Err}, 1);
    Clear_Err = 1'b1;
    step();
    Clear_Err = 1'b0;
    chk("to_err_cleared", {31'd0, Timeout_Err}, 0);

    // Done lands in the same cycle as the timeout: done wins
    eng_dly = 50;
    k = cyc;
    s = k + 2;
    sb.push_back('{s, 1});
    manual(1);
    run_to(s + 51);
    chk("tie_no_err", {31'd0, Timeout_Err}, 0);
    chk("tie_remain", {28'd0, Remain_Cnt}, 0);
    run_to(s + 61);
    chk("tie_idle", {31'd0, Busy}, 0);
    eng_dly = 20;
    run_to(cyc + 5);

    // Auto and manual become pending together: burst of 2 first, then auto.
    // The repeat request lands while the first is still pending and is dropped.
    a = cyc;
    Auto_En = 1'b1;
    sb.push_back('{a + 101, 2});
    sb.push_back('{a + 132, 1});
    sb.push_back('{a + 164, 1});
    run_to(a + 99);
    Manual_Req = 1'b1;
    Repeat_Num = 4'd2;
    step();
    Repeat_Num = 4'd5;
    step();
    Manual_Req = 1'b0;
    run_to(a + 190);
    Auto_En = 1'b0;
    run_to(a + 260);
    chk("prio_sb_empty", sb.size(), 0);
    chk("prio_idle", {31'd0, Busy}, 0);

    // Auto beacon from reset, dropped mid-gap of the third message
    Auto_En = 1'b1;
    apply_reset();
    r = cyc;
    sb.push_back('{r + 101, 1});
    sb.push_back('{r + 201, 1});
    sb.push_back('{r + 301, 1});
    run_to(r + 325);
    Auto_En = 1'b0;
    run_to(r + 450);
    chk("auto_sb_empty", sb.size(), 0);
    chk("auto_idle", {31'd0, Busy}, 0);

    // Asynchronous reset in the middle of RUN
    k = cyc;
    sb.push_back('{k + 2, 3});
    manual(3);
    run_to(k + 12);
    chk("rrun_busy_before", {31'd0, Busy}, 1);
    apply_reset();

    // Asynchronous reset during the start pulse
    k = cyc;
    sb.push_back('{k + 2, 2});
    manual(2);
    run_to(k + 2);
    chk("ren_en_before", {31'd0, SOS_En_Sig}, 1);
    apply_reset();
    run_to(cyc + 150);
    chk("rst_no_pulse", sb.size(), 0);
    chk("rst_idle", {31'd0, Busy}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
